// File: rtl/des_sbox_sched.sv
// Shares one combinational 6-to-4 S-box lookup across the 8 DES substitutions of a round,
// one chunk per cycle, and returns the assembled 32-bit word over a valid/ready handshake.
module des_sbox_sched #(
    parameter int NUM_BOX = 8,
    parameter int IN_W    = 6,
    parameter int OUT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_BOX*IN_W-1:0]  in_data,
    output logic [2:0]               sbox_sel,
    output logic [IN_W-1:0]          sbox_in,
    input  logic [OUT_W-1:0]         sbox_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_BOX*OUT_W-1:0] out_data,
    output logic                     busy,
    output logic [1:0]               dbg_state
);
    localparam int CNT_W = $clog2(NUM_BOX);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Handshakes: a word moves on an edge where valid and ready are both high;
    // valid holds its data until taken, ready never waits on valid.
    logic [1:0]               r_state;
    logic [1:0]               w_nxt_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [NUM_BOX*IN_W-1:0]  r_word;
    logic [NUM_BOX*OUT_W-1:0] r_out;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     w_accept;
    logic                     w_last;
    logic [CNT_W-1:0]         w_slot;

    assign w_accept = (r_state == S_IDLE) && r_in_ready && in_valid;
    assign w_last   = (r_cnt == CNT_W'(NUM_BOX - 1));
    // Chunk/nibble 0 lives at the MSB end, so the bit slot counts down as cnt counts up.
    assign w_slot   = CNT_W'(NUM_BOX - 1) - r_cnt;

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_nxt_state = S_RUN;
            S_RUN:   if (w_last)    w_nxt_state = S_DONE;
            S_DONE:  if (out_ready) w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
        if (flush) w_nxt_state = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_word      <= '0;
            r_out       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_in_ready  <= (w_nxt_state == S_IDLE);
            r_out_valid <= (w_nxt_state == S_DONE);
            if (flush) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_word <= in_data;
                r_cnt  <= '0;
            end else if (r_state == S_RUN) begin
                r_out[w_slot*OUT_W +: OUT_W] <= sbox_out;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sbox_sel = '0;
        sbox_in  = '0;
        if (r_state == S_RUN) begin
            sbox_sel = 3'(r_cnt);
            sbox_in  = r_word[w_slot*IN_W +: IN_W];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;
endmodule

// File: tb/tb_des_sbox_sched.sv
// Bench for des_sbox_sched: drives words through a real 8-table DES S-box model
// and checks schedule, results, handshakes, flush and async reset.
module tb_des_sbox_sched;
  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic [2:0]  sbox_sel;
  logic [5:0]  sbox_in;
  logic [3:0]  sbox_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 0;
  logic [31:0] exp_q[$];

  int sb_tab [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [3:0] sb_lookup(input logic [2:0] sel, input logic [5:0] b);
    int row, col;
    row = {b[5], b[0]};
    col = int'(b[4:1]);
    return 4'(sb_tab[sel][row*16 + col]);
  endfunction

  function automatic logic [5:0] chunk_of(input logic [47:0] w, input int k);
    return w[47-6*k -: 6];
  endfunction

  function automatic logic [31:0] des_sub(input logic [47:0] w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[31-4*k -: 4] = sb_lookup(3'(k), chunk_of(w, k));
    return r;
  endfunction

  assign sbox_out = sb_lookup(sbox_sel, sbox_in);

  des_sbox_sched dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sbox_sel(sbox_sel), .sbox_in(sbox_in), .sbox_out(sbox_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, " ready timeout"}, 64'(in_ready), 64'd1);
  endtask

  // scoreboard monitor for streamed results
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("b2b unexpected out", 64'(out_valid), 64'd0);
      else chk("b2b data", 64'(out_data), 64'(exp_q.pop_front()));
    end
  end

  // drivers
  task automatic run_word(input logic [47:0] din, input logic [31:0] exp, input string tag);
    wait_ready(tag);
    in_data  = din;
    in_valid = 1;
    step();
    in_valid = 0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, " sel"}, 64'(sbox_sel), 64'(k));
      chk({tag, " sbox_in"}, 64'(sbox_in), 64'(chunk_of(din, k)));
      chk({tag, " valid low in run"}, 64'(out_valid), 64'd0);
      step();
    end
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, " out_data"}, 64'(out_data), 64'(exp));
    chk({tag, " idle sel"}, 64'({sbox_sel, sbox_in}), 64'd0);
    out_ready = 1;
    step();
    out_ready = 0;
    chk({tag, " valid drop"}, 64'(out_valid), 64'd0);
    chk({tag, " ready back"}, 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    logic [47:0] din;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[5];

  initial begin
    logic [47:0] w;
    logic [31:0] held;
    int acc_cyc[4];
    int n;
    bit seen;

    rst = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    vecs[0] = '{48'h000000000000, 32'hEFA72C4D, "zero"};
    vecs[1] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "ones"};
    vecs[2] = '{48'h041041041041, 32'h03DDEAD1, "row1"};
    vecs[3] = '{48'h820820820820, 32'h40DA4917, "row2"};
    vecs[4] = '{48'h79E79E79E79E, 32'h7A8F9B17, "col15"};

    #2 rst = 1;
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset outs", 64'({out_valid, busy, sbox_sel, sbox_in}), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset state", 64'(dbg_state), 64'd0);
    #19 rst = 0;
    #1;
    chk("ready before edge", 64'(in_ready), 64'd0);
    step();
    chk("ready after release", 64'(in_ready), 64'd1);

    for (int i = 0; i < 5; i++) run_word(vecs[i].din, vecs[i].exp, vecs[i].name);

    // backpressure with new data pending
    wait_ready("bp");
    in_data = 48'hFFFFFFFFFFFF;
    in_valid = 1;
    step();
    in_data = 48'h0;
    for (int k = 0; k < 8; k++) step();
    chk("bp state done", 64'(dbg_state), 64'd2);
    held = out_data;
    chk("bp first data", 64'(held), 64'hD9CE3DCB);
    for (int i = 0; i < 20; i++) begin
      chk("bp in_ready low", 64'(in_ready), 64'd0);
      chk("bp data stable", 64'(out_data), 64'(held));
      chk("bp valid held", 64'(out_valid), 64'd1);
      step();
    end
    out_ready = 1;
    step();
    out_ready = 0;
    chk("bp valid drop", 64'(out_valid), 64'd0);
    chk("bp ready back", 64'(in_ready), 64'd1);
    step();
    in_valid = 0;
    chk("bp second accepted", 64'({busy, dbg_state}), 64'({1'b1, 2'd1}));
    for (int k = 0; k < 8; k++) step();
    chk("bp second data", 64'(out_data), 64'hEFA72C4D);
    out_ready = 1;
    step();
    out_ready = 0;

    // flush mid-run
    wait_ready("fl");
    in_data = 48'h820820820820;
    in_valid = 1;
    step();
    in_valid = 0;
    for (int k = 0; k < 4; k++) step();
    chk("fl cnt4 sel", 64'(sbox_sel), 64'd4);
    flush = 1;
    step();
    flush = 0;
    chk("fl idle", 64'({busy, out_valid, dbg_state}), 64'd0);
    chk("fl in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1;
      step();
    end
    chk("fl no out_valid", 64'(seen), 64'd0);
    run_word(48'h0, 32'hEFA72C4D, "after flush");

    // async reset mid-run
    wait_ready("ar");
    in_data = 48'h79E79E79E79E;
    in_valid = 1;
    step();
    in_valid = 0;
    for (int k = 0; k < 3; k++) step();
    #3 rst = 1;
    #1;
    chk("ar outs zero", 64'({in_ready, out_valid, busy, sbox_sel, sbox_in}), 64'd0);
    chk("ar data zero", 64'(out_data), 64'd0);
    #2 rst = 0;
    #1;
    chk("ar ready before edge", 64'(in_ready), 64'd0);
    step();
    chk("ar ready after edge", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid || busy) seen = 1;
      step();
    end
    chk("ar no pulse", 64'(seen), 64'd0);

    // back-to-back stream
    mon_en = 1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      w = {16'($urandom), $urandom};
      exp_q.push_back(des_sub(w));
      wait_ready("b2b");
      in_data = w;
      in_valid = 1;
      step();
      in_valid = 0;
      acc_cyc[i] = cyc;
      if (i > 0) chk("b2b spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd10);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      step();
      n++;
    end
    step();
    chk("b2b drained", 64'(exp_q.size()), 64'd0);
    mon_en = 0;
    out_ready = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
